// File: rtl/life_game_stepper.sv
// rtl/life_game_stepper.sv - Game of Life (B3/S23) generation engine on a toroidal 64xROWS world
//
// Purpose:
//   Acts as master of the life-game device cell port. On a start pulse it
//   reads the current frame word by word and writes the next generation
//   into the off-screen frame, one row at a time, using a three-row
//   sliding window (prev/cur/next).
//
// Ports:
//   clock          in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   start          in   one-cycle request for one generation (IDLE only)
//   cell_data_out  in   current-frame word at cell_address (combinational)
//   cell_address   out  word address {row[5:0], half}
//   cell_write     out  write strobe into the next frame
//   cell_data_in   out  next-generation word
//   busy           out  high while a generation is in progress
//   done           out  one-cycle pulse after the last write

module life_game_stepper #(
  parameter int ROWS = 48
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] cell_data_out,
  output logic [6:0]  cell_address,
  output logic        cell_write,
  output logic [31:0] cell_data_in,
  output logic        busy,
  output logic        done
);

  localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRELOAD,
    S_READ_LO,
    S_READ_HI,
    S_WRITE_LO,
    S_WRITE_HI,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [63:0] prev_row;
  logic [63:0] cur_row;
  logic [63:0] next_row;
  logic [63:0] new_row;
  logic [5:0]  y;
  logic [5:0]  y_below;
  logic [1:0]  phase;
  logic [31:0] data_hold;
  logic        armed;
  logic        accept;
  logic [3:0]  nbr;

  // The row below wraps to row 0 on the last row; row 0 is still intact in
  // the current frame because all writes land in the other frame.
  assign y_below = (y == LAST_ROW) ? 6'd0 : y + 6'd1;

  // armed is low for the first cycle after reset release so a start that
  // coincides with the release is dropped.
  assign accept = start && armed;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      prev_row  <= '0;
      cur_row   <= '0;
      next_row  <= '0;
      y         <= '0;
      phase     <= '0;
      data_hold <= '0;
      armed     <= 1'b0;
    end else begin
      state <= state_next;
      armed <= 1'b1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            y     <= '0;
            phase <= '0;
          end
        end
        S_PRELOAD: begin
          phase <= phase + 2'd1;
          case (phase)
            2'd0:    prev_row[31:0]  <= cell_data_out;
            2'd1:    prev_row[63:32] <= cell_data_out;
            2'd2:    cur_row[31:0]   <= cell_data_out;
            default: cur_row[63:32]  <= cell_data_out;
          endcase
        end
        S_READ_LO:  next_row[31:0]  <= cell_data_out;
        S_READ_HI:  next_row[63:32] <= cell_data_out;
        S_WRITE_LO: data_hold <= new_row[31:0];
        S_WRITE_HI: begin
          data_hold <= new_row[63:32];
          prev_row  <= cur_row;
          cur_row   <= next_row;
          if (y != LAST_ROW) begin
            y <= y + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-row computation: 8-neighbour count with horizontal wrap, B3/S23.
  always_comb begin
    new_row = '0;
    nbr     = '0;
    for (int x = 0; x < 64; x++) begin
      nbr = 4'(prev_row[(x + 63) % 64]) + 4'(prev_row[x]) + 4'(prev_row[(x + 1) % 64])
          + 4'(cur_row[(x + 63) % 64])                     + 4'(cur_row[(x + 1) % 64])
          + 4'(next_row[(x + 63) % 64]) + 4'(next_row[x]) + 4'(next_row[(x + 1) % 64]);
      new_row[x] = (nbr == 4'd3) || ((nbr == 4'd2) && cur_row[x]);
    end
  end

  always_comb begin
    state_next   = state;
    cell_address = '0;
    cell_write   = 1'b0;
    cell_data_in = data_hold;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = S_PRELOAD;
        end
      end
      S_PRELOAD: begin
        busy = 1'b1;
        case (phase)
          2'd0:    cell_address = {LAST_ROW, 1'b0};
          2'd1:    cell_address = {LAST_ROW, 1'b1};
          2'd2:    cell_address = 7'd0;
          default: cell_address = 7'd1;
        endcase
        if (phase == 2'd3) begin
          state_next = S_READ_LO;
        end
      end
      S_READ_LO: begin
        busy         = 1'b1;
        cell_address = {y_below, 1'b0};
        state_next   = S_READ_HI;
      end
      S_READ_HI: begin
        busy         = 1'b1;
        cell_address = {y_below, 1'b1};
        state_next   = S_WRITE_LO;
      end
      S_WRITE_LO: begin
        busy         = 1'b1;
        cell_address = {y, 1'b0};
        cell_write   = 1'b1;
        cell_data_in = new_row[31:0];
        state_next   = S_WRITE_HI;
      end
      S_WRITE_HI: begin
        busy         = 1'b1;
        cell_address = {y, 1'b1};
        cell_write   = 1'b1;
        cell_data_in = new_row[63:32];
        state_next   = (y == LAST_ROW) ? S_DONE : S_READ_LO;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule
